// File: rtl/multi_ch_sync_pkg.sv
// Shared constants and slice helper for the multi-channel bus synchroniser.
// Parity support follows MULTI_CH_DATA_SYNC_PARITY_EN.
package multi_ch_sync_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 8;
  localparam int MAX_CH     = 8;

`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Bit offset of channel ch inside a flat bus of per-channel width 'width'.
  function automatic int ch_offset(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/data_sync_ch.sv
// One synchroniser channel: enable chain, edge detect, one-shot capture, ready handshake,
// ack toggle, sticky overrun and (with MULTI_CH_DATA_SYNC_PARITY_EN) sticky parity error.
module data_sync_ch
  import multi_ch_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = 0,
  localparam int SLICE_W    = BUS_WIDTH + PARITY_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SLICE_W-1:0]   data,
  input  logic                 enable,
  input  logic                 ready,
  input  logic                 ovr_clr,
  output logic [BUS_WIDTH-1:0] sync_data,
  output logic                 valid,
  output logic                 pulse,
  output logic                 ack,
  output logic                 overrun
`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
  ,
  output logic                 par_err
`endif
);

  logic [NUM_STAGES-1:0] chain;
  logic                  hist;
  logic                  ev;
  logic                  ovr_set;

  // NOTE: non-blocking assignments let every stage sample its pre-edge neighbour;
  // blocking ones would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[NUM_STAGES-2:0], enable};
      hist  <= chain[NUM_STAGES-1];
    end
  end

  // NOTE: default first so no path through this block can infer a latch.
  always_comb begin
    ev = 1'b0;
    if (TOGGLE_MODE != 0) ev = chain[NUM_STAGES-1] ^ hist;
    else                  ev = chain[NUM_STAGES-1] & ~hist;
  end

  // A capture over unconsumed data is an overrun; a coincident clear loses to the set.
  assign ovr_set = ev & valid & ~ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_data <= '0;
      valid     <= 1'b0;
      pulse     <= 1'b0;
      ack       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pulse   <= ev;
      overrun <= ovr_set | (overrun & ~ovr_clr);
      if (ev) begin
        sync_data <= data[BUS_WIDTH-1:0];
        valid     <= 1'b1;
        ack       <= ~ack;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
  logic par_set;

  // Even parity over data plus parity bit: any odd total is an error.
  assign par_set = ev & (^data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= par_set | (par_err & ~ovr_clr);
  end
`endif

endmodule

// File: rtl/multi_ch_data_sync.sv
// Multi-channel multi-cycle-path bus synchroniser into the CLK domain.
// Define MULTI_CH_DATA_SYNC_PARITY_EN to add a per-channel even-parity bit and par_err.
module multi_ch_data_sync
  import multi_ch_sync_pkg::*;
#(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 2,
  parameter int TOGGLE_MODE = 0,
  localparam int SLICE_W    = BUS_WIDTH + PARITY_BITS
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*SLICE_W-1:0]   unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  input  logic [NUM_CH-1:0]           sync_ready,
  input  logic [NUM_CH-1:0]           ovr_clr,
  output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
  output logic [NUM_CH-1:0]           sync_valid,
  output logic [NUM_CH-1:0]           enable_pulse,
  output logic [NUM_CH-1:0]           ack_toggle,
  output logic [NUM_CH-1:0]           overrun
`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
  ,
  output logic [NUM_CH-1:0]           par_err
`endif
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    data_sync_ch #(
      .NUM_STAGES  (NUM_STAGES),
      .BUS_WIDTH   (BUS_WIDTH),
      .TOGGLE_MODE (TOGGLE_MODE)
    ) u_ch (
      .clk       (CLK),
      .rst_n     (RST),
      .data      (unsync_bus[ch_offset(i, SLICE_W) +: SLICE_W]),
      .enable    (bus_enable[i]),
      .ready     (sync_ready[i]),
      .ovr_clr   (ovr_clr[i]),
      .sync_data (sync_bus[ch_offset(i, BUS_WIDTH) +: BUS_WIDTH]),
      .valid     (sync_valid[i]),
      .pulse     (enable_pulse[i]),
      .ack       (ack_toggle[i]),
      .overrun   (overrun[i])
`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
      ,
      .par_err   (par_err[i])
`endif
    );
  end

`ifndef SYNTHESIS
  param_range_a : assert property (@(posedge CLK)
    (NUM_STAGES >= MIN_STAGES) && (NUM_STAGES <= MAX_STAGES) &&
    (NUM_CH >= 1) && (NUM_CH <= MAX_CH) && (TOGGLE_MODE >= 0) && (TOGGLE_MODE <= 1))
    else $error("multi_ch_data_sync: parameter out of range");
`endif

endmodule

// File: tb/tb_multi_ch_data_sync.sv
// Self-checking bench: a level-mode and a toggle-mode instance compared every cycle
// against an enable-sample-history reference model.
`timescale 1ns/1ps
module tb_multi_ch_data_sync;

  localparam int NUM_CH = 2;
  localparam int BW     = 8;
  localparam int STG_L  = 2;
  localparam int STG_T  = 3;
`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
  localparam int SW = BW + 1;
  localparam int VW = NUM_CH*BW + 5*NUM_CH;
`else
  localparam int SW = BW;
  localparam int VW = NUM_CH*BW + 4*NUM_CH;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_CH*SW-1:0] unsync_bus = '0, t_unsync_bus = '0;
  logic [NUM_CH-1:0]    bus_enable = '0, sync_ready = '0, ovr_clr = '0;
  logic [NUM_CH-1:0]    t_bus_enable = '0, t_sync_ready = '0, t_ovr_clr = '0;
  logic [NUM_CH*BW-1:0] sync_bus, t_sync_bus;
  logic [NUM_CH-1:0]    sync_valid, enable_pulse, ack_toggle, overrun;
  logic [NUM_CH-1:0]    t_sync_valid, t_enable_pulse, t_ack_toggle, t_overrun;
`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
  logic [NUM_CH-1:0]    par_err, t_par_err;
`endif

  multi_ch_data_sync #(.NUM_STAGES(STG_L), .BUS_WIDTH(BW), .NUM_CH(NUM_CH), .TOGGLE_MODE(0)) dut (
    .CLK(clk), .RST(rst_n), .unsync_bus(unsync_bus), .bus_enable(bus_enable),
    .sync_ready(sync_ready), .ovr_clr(ovr_clr), .sync_bus(sync_bus), .sync_valid(sync_valid),
    .enable_pulse(enable_pulse), .ack_toggle(ack_toggle), .overrun(overrun)
`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
    , .par_err(par_err)
`endif
  );

  multi_ch_data_sync #(.NUM_STAGES(STG_T), .BUS_WIDTH(BW), .NUM_CH(NUM_CH), .TOGGLE_MODE(1)) dut_t (
    .CLK(clk), .RST(rst_n), .unsync_bus(t_unsync_bus), .bus_enable(t_bus_enable),
    .sync_ready(t_sync_ready), .ovr_clr(t_ovr_clr), .sync_bus(t_sync_bus), .sync_valid(t_sync_valid),
    .enable_pulse(t_enable_pulse), .ack_toggle(t_ack_toggle), .overrun(t_overrun)
`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
    , .par_err(t_par_err)
`endif
  );

  logic [VW-1:0] obs_l, obs_t;
`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
  assign obs_l = {sync_bus, sync_valid, enable_pulse, ack_toggle, overrun, par_err};
  assign obs_t = {t_sync_bus, t_sync_valid, t_enable_pulse, t_ack_toggle, t_overrun, t_par_err};
`else
  assign obs_l = {sync_bus, sync_valid, enable_pulse, ack_toggle, overrun};
  assign obs_t = {t_sync_bus, t_sync_valid, t_enable_pulse, t_ack_toggle, t_overrun};
`endif

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: enable samples per edge (bit 0 = most recent), plus output state.
  logic [15:0]   samp    [2][NUM_CH];
  logic [BW-1:0] m_bus   [2][NUM_CH];
  logic          m_valid [2][NUM_CH];
  logic          m_pulse [2][NUM_CH];
  logic          m_ack   [2][NUM_CH];
  logic          m_ovr   [2][NUM_CH];
  logic          m_perr  [2][NUM_CH];

  function automatic logic [VW-1:0] model_vec(input int d);
    logic [NUM_CH*BW-1:0] b;
    logic [NUM_CH-1:0] v, p, a, o, e;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      b[ch*BW +: BW] = m_bus[d][ch];
      v[ch] = m_valid[d][ch];
      p[ch] = m_pulse[d][ch];
      a[ch] = m_ack[d][ch];
      o[ch] = m_ovr[d][ch];
      e[ch] = m_perr[d][ch];
    end
`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
    return {b, v, p, a, o, e};
`else
    return {b, v, p, a, o};
`endif
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < NUM_CH; ch++) begin
        samp[d][ch] = '0; m_bus[d][ch] = '0; m_valid[d][ch] = 1'b0; m_pulse[d][ch] = 1'b0;
        m_ack[d][ch] = 1'b0; m_ovr[d][ch] = 1'b0; m_perr[d][ch] = 1'b0;
      end
  endtask

  // One clock edge: model sees the same pre-edge inputs as the DUTs; returns 1ns later.
  task automatic tick();
    logic [NUM_CH*SW-1:0] din [2];
    logic [NUM_CH-1:0] en [2], rdy [2], clr [2];
    din[0] = unsync_bus;  din[1] = t_unsync_bus;
    en[0]  = bus_enable;  en[1]  = t_bus_enable;
    rdy[0] = sync_ready;  rdy[1] = t_sync_ready;
    clr[0] = ovr_clr;     clr[1] = t_ovr_clr;
    @(posedge clk);
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          int n;
          logic ev, set_ovr;
          logic [SW-1:0] slice;
          n = (d == 0) ? STG_L : STG_T;
          // Event when the sample taken n edges ago differs from the one before it.
          if (d == 0) ev = samp[d][ch][n-1] & ~samp[d][ch][n];
          else        ev = samp[d][ch][n-1] ^ samp[d][ch][n];
          slice = din[d][ch*SW +: SW];
          set_ovr = ev & m_valid[d][ch] & ~rdy[d][ch];
          m_pulse[d][ch] = ev;
          if (ev) begin
            m_bus[d][ch]   = slice[BW-1:0];
            m_ack[d][ch]   = ~m_ack[d][ch];
            m_valid[d][ch] = 1'b1;
          end else if (m_valid[d][ch] && rdy[d][ch]) begin
            m_valid[d][ch] = 1'b0;
          end
          m_ovr[d][ch]  = set_ovr | (m_ovr[d][ch] & ~clr[d][ch]);
          m_perr[d][ch] = (ev & (^slice)) | (m_perr[d][ch] & ~clr[d][ch]);
          samp[d][ch]   = {samp[d][ch][14:0], en[d][ch]};
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({obs_l, obs_t} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %h / %h, expected all zero", obs_l, obs_t);
    end
    repeat (3) tick();
    release_reset();
    repeat (4) begin
      tick();
      n_cmp++;
      if (obs_l !== model_vec(0) || obs_t !== model_vec(1)) begin
        n_fail++;
        $display("FAIL reset_idle: got %h / %h, expected %h / %h", obs_l, obs_t, model_vec(0), model_vec(1));
      end
    end
  endtask

  task automatic test_basic_capture();
    logic [31:0] r;
    r = $urandom;
    unsync_bus = r[NUM_CH*SW-1:0];
    unsync_bus[0 +: SW] = '0;
    unsync_bus[0 +: BW] = 8'hA5;
    sync_ready = '0;
    bus_enable[0] = 1'b1;
    repeat (STG_L) tick();
    n_cmp++;
    if (enable_pulse !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_not_early: pulse %b, expected 00", enable_pulse);
    end
    tick();
    n_cmp++;
    if (sync_bus[0 +: BW] !== 8'hA5 || sync_bus[BW +: BW] !== 8'h00 || enable_pulse !== 2'b01 ||
        sync_valid !== 2'b01 || ack_toggle !== 2'b01) begin
      n_fail++;
      $display("FAIL basic_capture: bus %h pulse %b valid %b ack %b, expected 00a5 01 01 01",
               sync_bus, enable_pulse, sync_valid, ack_toggle);
    end
    tick();
    n_cmp++;
    if (obs_l !== model_vec(0) || enable_pulse !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_one_pulse: got %h, expected %h", obs_l, model_vec(0));
    end
  endtask

  task automatic test_level_hold();
    int pulses, cap;
    sync_ready = '1;
    bus_enable[0] = 1'b0;
    repeat (6) tick();
    bus_enable[0] = 1'b1;
    pulses = 0;
    cap = -1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++;
      if (obs_l !== model_vec(0)) begin
        n_fail++;
        $display("FAIL level_hold_model: cycle %0d got %h, expected %h", i, obs_l, model_vec(0));
      end
      if (enable_pulse[0]) begin
        pulses++;
        cap = i;
      end
      if (cap >= 0 && i == cap + 1) begin
        n_cmp++;
        if (sync_valid[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL level_hold_valid_drop: valid %b, expected 0", sync_valid[0]);
        end
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL level_hold_pulses: got %0d, expected 1", pulses);
    end
  endtask

  task automatic test_overrun();
    sync_ready = '0;
    bus_enable[1] = 1'b0;
    repeat (4) tick();
    unsync_bus[SW +: SW] = '0;
    unsync_bus[SW +: BW] = 8'h11;
    bus_enable[1] = 1'b1;
    repeat (6) tick();
    bus_enable[1] = 1'b0;
    repeat (3) tick();
    unsync_bus[SW +: BW] = 8'h22;
    bus_enable[1] = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (sync_bus[BW +: BW] !== 8'h22 || overrun !== 2'b10 || obs_l !== model_vec(0)) begin
      n_fail++;
      $display("FAIL overrun_set: bus %h ovr %b, expected 22 10", sync_bus[BW +: BW], overrun);
    end
    ovr_clr[1] = 1'b1;
    tick();
    n_cmp++;
    if (overrun !== 2'b00) begin
      n_fail++;
      $display("FAIL overrun_clear: ovr %b, expected 00", overrun);
    end
    bus_enable[1] = 1'b0;
    repeat (3) tick();
    bus_enable[1] = 1'b1;
    repeat (STG_L + 1) tick();
    n_cmp++;
    if (overrun[1] !== 1'b1 || enable_pulse[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set_wins: ovr %b pulse %b, expected 1 1", overrun[1], enable_pulse[1]);
    end
    tick();
    n_cmp++;
    if (overrun[1] !== 1'b0 || obs_l !== model_vec(0)) begin
      n_fail++;
      $display("FAIL overrun_clear_after: ovr %b, expected 0", overrun[1]);
    end
    ovr_clr = '0;
  endtask

  task automatic test_toggle();
    int pulses;
    logic [31:0] r;
    r = $urandom;
    t_unsync_bus = r[NUM_CH*SW-1:0];
    t_sync_ready = '1;
    pulses = 0;
    t_bus_enable[0] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 8) t_bus_enable[0] = 1'b0;
      tick();
      if (t_enable_pulse[0]) pulses++;
      n_cmp++;
      if (obs_t !== model_vec(1)) begin
        n_fail++;
        $display("FAIL toggle_model: cycle %0d got %h, expected %h", i, obs_t, model_vec(1));
      end
    end
    n_cmp++;
    if (pulses != 2 || t_ack_toggle[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_captures: pulses %0d ack %b, expected 2 0", pulses, t_ack_toggle[0]);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    bus_enable = '0;
    repeat (4) tick();
    bus_enable[0] = 1'b1;
    repeat (STG_L) tick();
    #2;
    do_reset();
    n_cmp++;
    if ({obs_l, obs_t} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h / %h, expected all zero", obs_l, obs_t);
    end
    bus_enable = '0;
    t_bus_enable = '0;
    repeat (2) tick();
    release_reset();
    pulses = 0;
    repeat (8) begin
      tick();
      if (enable_pulse != 0 || t_enable_pulse != 0) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_pulse: got %0d pulses, expected 0", pulses);
    end
    do_reset();
    bus_enable[0] = 1'b1;
    repeat (2) tick();
    release_reset();
    pulses = 0;
    repeat (10) begin
      tick();
      if (enable_pulse[0]) pulses++;
      n_cmp++;
      if (obs_l !== model_vec(0)) begin
        n_fail++;
        $display("FAIL reset_release_model: got %h, expected %h", obs_l, model_vec(0));
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL reset_release_high: got %0d pulses, expected 1", pulses);
    end
  endtask

  task automatic test_random();
    logic [31:0] r, dl, dt;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom; dl = $urandom; dt = $urandom;
      unsync_bus   = dl[NUM_CH*SW-1:0];
      t_unsync_bus = dt[NUM_CH*SW-1:0];
      bus_enable   = bus_enable ^ (r[0 +: NUM_CH] & r[2 +: NUM_CH]);
      t_bus_enable = t_bus_enable ^ (r[4 +: NUM_CH] & r[6 +: NUM_CH]);
      sync_ready   = r[8 +: NUM_CH];
      t_sync_ready = r[10 +: NUM_CH];
      ovr_clr      = r[12 +: NUM_CH] & r[14 +: NUM_CH] & r[16 +: NUM_CH];
      t_ovr_clr    = r[18 +: NUM_CH] & r[20 +: NUM_CH] & r[22 +: NUM_CH];
      tick();
      n_cmp++;
      if (obs_l !== model_vec(0) || obs_t !== model_vec(1)) begin
        n_fail++;
        $display("FAIL random: cycle %0d got %h / %h, expected %h / %h",
                 i, obs_l, obs_t, model_vec(0), model_vec(1));
      end
    end
    ovr_clr = '0;
    t_ovr_clr = '0;
  endtask

`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
  task automatic test_parity();
    sync_ready = '1;
    bus_enable[0] = 1'b0;
    ovr_clr = '1;
    tick();
    ovr_clr = '0;
    repeat (4) tick();
    unsync_bus[0 +: SW] = 9'h103;
    bus_enable[0] = 1'b1;
    repeat (STG_L + 1) tick();
    n_cmp++;
    if (par_err[0] !== 1'b1 || sync_bus[0 +: BW] !== 8'h03) begin
      n_fail++;
      $display("FAIL parity_set: par_err %b bus %h, expected 1 03", par_err[0], sync_bus[0 +: BW]);
    end
    ovr_clr[0] = 1'b1;
    tick();
    ovr_clr[0] = 1'b0;
    bus_enable[0] = 1'b0;
    repeat (4) tick();
    unsync_bus[0 +: SW] = 9'h003;
    bus_enable[0] = 1'b1;
    repeat (STG_L + 1) tick();
    n_cmp++;
    if (par_err[0] !== 1'b0 || enable_pulse[0] !== 1'b1 || obs_l !== model_vec(0)) begin
      n_fail++;
      $display("FAIL parity_clean: par_err %b pulse %b, expected 0 1", par_err[0], enable_pulse[0]);
    end
  endtask
`endif

  initial begin
    model_clear();
    test_reset();
    test_basic_capture();
    test_level_hold();
    test_overrun();
    test_toggle();
    test_reset_mid();
    test_random();
`ifdef MULTI_CH_DATA_SYNC_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_ch_data_sync.md
Name: multi_ch_data_sync

Overview:
Parametrised multi-channel multi-cycle-path bus synchroniser for CDC from slower or async domains into the CLK domain.
- Each channel synchronises its own enable through a NUM_STAGES flop chain, edge-detects it, and captures its data bus once.
- Per channel it adds: selectable level/toggle enable mode, a hold-until-ready output handshake, an ack toggle returned to the source, and a sticky overrun flag.
- Instantiated at system/UART boundaries in place of per-bus single-channel synchronisers.

Parameters:
NUM_STAGES, 2, synchroniser depth for each enable; legal range 2..8.
BUS_WIDTH, 8, data width per channel.
NUM_CH, 2, number of independent channels; legal range 1..8.
TOGGLE_MODE, 0, 0 = rising edge of bus_enable is an event; 1 = any transition of bus_enable is an event.

Ports:
CLK  in  1  destination clock
RST  in  1  asynchronous active-low reset
unsync_bus  in  NUM_CH*BUS_WIDTH  source data; channel i is bits [i*BUS_WIDTH +: BUS_WIDTH]
bus_enable  in  NUM_CH  source enable (level or toggle), one per channel
sync_ready  in  NUM_CH  consumer accepts sync_bus[i] while sync_valid[i]=1
ovr_clr  in  NUM_CH  clears overrun[i]
sync_bus  out  NUM_CH*BUS_WIDTH  captured data, registered
sync_valid  out  NUM_CH  data held in sync_bus[i] is valid
enable_pulse  out  NUM_CH  one-cycle pulse on each capture
ack_toggle  out  NUM_CH  flips on each capture; source synchronises it back
overrun  out  NUM_CH  sticky; a capture occurred while valid[i]=1 and ready[i]=0

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous, active-low. All flops reset to 0: sync_bus, sync_valid, enable_pulse, ack_toggle, overrun, sync chains and the edge-history flop.
- Channels are fully independent. No cross-channel state.
- Per channel: chain s[0..NUM_STAGES-1], with s[0] <= bus_enable[i]. Edge-history flop h <= s[last].
- Event detection:
  - TOGGLE_MODE=0: ev = s[last] & ~h.
  - TOGGLE_MODE=1: ev = s[last] ^ h.
- Latency: bus_enable[i] is first sampled at edge k. Then ev is high combinationally after edge k+NUM_STAGES-1. At edge k+NUM_STAGES: sync_bus[i] <= unsync_bus slice, enable_pulse[i]=1, sync_valid[i]=1, ack_toggle[i] flips.
- enable_pulse[i] lasts exactly one cycle per event. Level mode: one pulse per rising edge, however long the level is held.
- Handshake:
  - sync_valid[i] falls on an edge where valid=1, ready=1 and no new ev.
  - If ev and ready coincide, the new data loads and valid stays 1; no overrun.
- Overrun:
  - ev with valid=1 and ready=0: new data overwrites sync_bus[i], overrun[i] <= 1.
  - overrun holds until ovr_clr[i]. If ovr_clr and a new overrun coincide, set wins.
- sync_bus[i] is unchanged between captures, including after valid drops.
- Source contract: unsync_bus slice is stable from its enable event until ack_toggle is seen back. Violations are not detected.
- Reset mid-operation clears all state immediately. An enable already high at reset release produces one event in level mode, about NUM_STAGES cycles later.

Optional Feature:
Macro MULTI_CH_DATA_SYNC_PARITY_EN.
- Defined:
  - unsync_bus carries one extra even-parity bit per channel at slice bit BUS_WIDTH; port widths become NUM_CH*(BUS_WIDTH+1).
  - Added output par_err [NUM_CH], sticky, set on a capture whose data+parity XOR is 1, cleared by ovr_clr.
  - sync_bus still excludes the parity bit.
- Undefined: no parity bit and no par_err port; widths as listed above.

Decomposition:
- Package multi_ch_sync_pkg: localparams MIN_STAGES=2 and MAX_CH=8, plus a function for the channel slice offset.
- Sub-module data_sync_ch implements one channel (chain, edge detect, capture, handshake, overrun, parity). The top module is a generate loop over NUM_CH plus parameter-range assertions.

Test Plan:
- NUM_STAGES=2, level mode, ch0 bus=0xA5, enable raised at edge 10 → edge 12: sync_bus[0]=0xA5, one-cycle enable_pulse, sync_valid=1, ack_toggle=1; ch1 unchanged.
- Hold enable high 50 cycles with ready=1 → exactly one pulse; valid drops the cycle after capture.
- ready=0, two events with data 0x11 then 0x22 → sync_bus=0x22, overrun=1; ovr_clr pulse → overrun=0.
- TOGGLE_MODE=1, toggle enable 0→1→0 eight cycles apart → two captures, ack_toggle ends at 0.
- Assert RST low while an event is in the chain → all outputs 0 asynchronously; no pulse after release when enable=0.
- PARITY_EN defined, data 0x03 with parity=1 → par_err=1; data 0x03 with parity=0 → no set.
